// File: rtl/pll_reconfig_pkg.sv
// rtl/pll_reconfig_pkg.sv - shared types and constants for the PLL reconfiguration sequencer
package pll_reconfig_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    TBL,
    GAP,
    START,
    LOCK
  } state_t;

  localparam int AV_ADDR_W = 6;
  localparam int AV_DATA_W = 32;

  typedef struct packed {
    logic [AV_ADDR_W-1:0] addr;
    logic [AV_DATA_W-1:0] data;
  } av_wr_t;

  localparam int DEF_MODE_REG_ADDR = 0;
  localparam int DEF_START_ADDR    = 2;

  // Index widths never collapse to zero bits, even for a single profile or entry.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// rtl/pll_reconfig_seq_if.sv - Avalon-MM management port plus external table lookup bundle
interface pll_reconfig_seq_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int MODE_W = 1,
  parameter int IDX_W  = 2
);
  logic              mgmt_waitrequest;
  logic              mgmt_write;
  logic [ADDR_W-1:0] mgmt_address;
  logic [DATA_W-1:0] mgmt_writedata;
  logic [MODE_W-1:0] tbl_mode;
  logic [IDX_W-1:0]  tbl_idx;
  logic [ADDR_W-1:0] tbl_addr;
  logic [DATA_W-1:0] tbl_data;
  logic              tbl_last;

  modport master (
    input  mgmt_waitrequest, tbl_addr, tbl_data, tbl_last,
    output mgmt_write, mgmt_address, mgmt_writedata, tbl_mode, tbl_idx
  );

  modport slave (
    output mgmt_waitrequest, tbl_addr, tbl_data, tbl_last,
    input  mgmt_write, mgmt_address, mgmt_writedata, tbl_mode, tbl_idx
  );
endinterface

// File: rtl/cdc_sync.sv
// rtl/cdc_sync.sv - multi-stage flop synchroniser with async active-low reset
module cdc_sync #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] chain_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= RESET_VAL;
    end else begin
      chain_q[0] <= d;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q = chain_q[STAGES-1];
endmodule

// File: rtl/pll_reconfig_seq.sv
// rtl/pll_reconfig_seq.sv - debounced mode request replays a per-profile PLL register table over Avalon-MM
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_MODES     = 2,
  parameter int MAX_WRITES    = 4,
  parameter int ADDR_W        = 6,
  parameter int DATA_W        = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int GAP_CYCLES    = 3,
  parameter int MODE_REG_ADDR = DEF_MODE_REG_ADDR,
  parameter int START_ADDR    = DEF_START_ADDR,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int RESET_MODE    = 0,
  localparam int MODE_W       = clog2_min1(NUM_MODES),
  localparam int IDX_W        = clog2_min1(MAX_WRITES)
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              locked,
  pll_reconfig_seq_if.master bus,
  output logic              busy,
  output logic [MODE_W-1:0] applied_mode,
  output logic              error
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  logic [MODE_W-1:0] mode_s, mode_q;
  logic              locked_s;
  logic [SW-1:0]     stab_q;
  logic              stable, req_bad, accepted;

  state_t            state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [LW-1:0]     lock_q, lock_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [MODE_W-1:0] target_q, target_d, applied_q, applied_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d, busy_q, busy_d, error_q, error_d;
  logic              to_start_q, to_start_d, last_q, last_d, low_seen_q, low_seen_d;

  cdc_sync #(.WIDTH(MODE_W), .STAGES(SYNC_STAGES), .RESET_VAL(MODE_W'(RESET_MODE))) u_sync_mode (
    .clk(clk_sys), .rst_n(reset), .d(mode_req), .q(mode_s)
  );

  cdc_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_locked (
    .clk(clk_sys), .rst_n(reset), .d(locked), .q(locked_s)
  );

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_W'(RESET_MODE);
      stab_q <= '0;
    end else begin
      mode_q <= mode_s;
      if (mode_s != mode_q)
        stab_q <= '0;
      else if (stab_q != SW'(STABLE_CYCLES))
        stab_q <= stab_q + 1'b1;
    end
  end

  assign stable   = (stab_q == SW'(STABLE_CYCLES)) && (mode_s == mode_q);
  assign req_bad  = int'(mode_s) >= NUM_MODES;
  assign accepted = wr_q && !bus.mgmt_waitrequest;

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      lock_q     <= '0;
      idx_q      <= '0;
      target_q   <= MODE_W'(RESET_MODE);
      applied_q  <= MODE_W'(RESET_MODE);
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      to_start_q <= 1'b0;
      last_q     <= 1'b0;
      low_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      lock_q     <= lock_d;
      idx_q      <= idx_d;
      target_q   <= target_d;
      applied_q  <= applied_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      to_start_q <= to_start_d;
      last_q     <= last_d;
      low_seen_q <= low_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    lock_d     = lock_q;
    idx_d      = idx_q;
    target_d   = target_q;
    applied_d  = applied_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = wr_q;
    busy_d     = busy_q;
    error_d    = error_q;
    to_start_d = to_start_q;
    last_d     = last_q;
    low_seen_d = low_seen_q;

    case (state_q)
      IDLE: begin
        if (stable && (mode_s != applied_q)) begin
          if (req_bad) begin
            error_d = 1'b1;
          end else begin
            target_d = mode_s;
            idx_d    = '0;
            busy_d   = 1'b1;
            wr_d     = 1'b1;
            addr_d   = ADDR_W'(MODE_REG_ADDR);
            data_d   = '0;
            state_d  = PRE;
          end
        end
      end
      PRE, TBL: begin
        if (accepted) begin
          wr_d       = 1'b0;
          gap_d      = '0;
          state_d    = GAP;
          to_start_d = (state_q == TBL) && last_q;
          if ((state_q == TBL) && !last_q) idx_d = idx_q + 1'b1;
        end
      end
      GAP: begin
        // The table entry is loaded on the last idle cycle, so the lookup has settled for the whole gap.
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          wr_d = 1'b1;
          if (to_start_q) begin
            addr_d  = ADDR_W'(START_ADDR);
            data_d  = '0;
            state_d = START;
          end else begin
            addr_d  = bus.tbl_addr;
            data_d  = bus.tbl_data;
            last_d  = bus.tbl_last || (idx_q == IDX_W'(MAX_WRITES - 1));
            state_d = TBL;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      START: begin
        if (accepted) begin
          wr_d       = 1'b0;
          lock_d     = '0;
          low_seen_d = 1'b0;
          state_d    = LOCK;
        end
      end
      LOCK: begin
        if (low_seen_q && locked_s) begin
          applied_d = target_q;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (lock_q == LW'(LOCK_TIMEOUT - 1)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          lock_d = lock_q + 1'b1;
          if (!locked_s) low_seen_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mgmt_write     = wr_q;
  assign bus.mgmt_address   = addr_q;
  assign bus.mgmt_writedata = data_q;
  assign bus.tbl_mode       = target_q;
  assign bus.tbl_idx        = idx_q;
  assign busy               = busy_q;
  assign applied_mode       = applied_q;
  assign error              = error_q;
endmodule
